uart_rx_deser_cfg: RTL and testbench



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx_deser_cfg.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_deser_cfg.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive family: FSM states, word-width floor,
// parity modes and the oversample counter width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_PARITY     = 3'd3,
    ST_STOP1      = 3'd4,
    ST_STOP2      = 3'd5,
    ST_BREAK_WAIT = 3'd6
  } uart_rx_state_e;

  localparam int UART_MIN_WORD_WIDTH = 5;

  localparam logic UART_PARITY_EVEN = 1'b0;
  localparam logic UART_PARITY_ODD  = 1'b1;

  function automatic int uart_ctr_width(input int oversampling);
    return (oversampling <= 2) ? 1 : $clog2(oversampling);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an idle-high serial line; resets to 1 so a
// receiver never sees a phantom start bit coming out of reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deser_cfg.sv
// Runtime-configurable UART receiver with one-deep output holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around each mid-bit sample.
module uart_rx_deser_cfg
  import uart_pkg::*;
#(
  parameter int MAX_WORD_WIDTH = 9,
  parameter int OVERSAMPLING   = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                tick,
  input  logic                                din,
  input  logic [$clog2(MAX_WORD_WIDTH+1)-1:0] cfg_word_len,
  input  logic                                cfg_parity_en,
  input  logic                                cfg_parity_odd,
  input  logic                                cfg_stop2,
  output logic [MAX_WORD_WIDTH-1:0]           dout,
  output logic                                dout_valid,
  input  logic                                dout_ready,
  output logic                                parity_err,
  output logic                                frame_err,
  output logic                                break_det,
  output logic                                overrun,
  output logic                                busy
);

  localparam int WLW = $clog2(MAX_WORD_WIDTH + 1);
  localparam int CW  = uart_ctr_width(OVERSAMPLING);
`ifdef UART_RX_MAJORITY_EN
  localparam int VOTE_DLY = 1;
`else
  localparam int VOTE_DLY = 0;
`endif
  // With voting, the decision lands on mid+1, so every count is shifted one tick.
  localparam logic [CW-1:0] START_LOAD = CW'(OVERSAMPLING / 2 - 1 + VOTE_DLY);
  localparam logic [CW-1:0] BIT_LOAD   = CW'(OVERSAMPLING - 1);

  uart_rx_state_e              state_q, state_d;
  logic [CW-1:0]               tick_ctr_q;
  logic [WLW-1:0]              bit_ctr_q;
  logic [WLW-1:0]              wl_q;
  logic [MAX_WORD_WIDTH-1:0]   shreg_q;
  logic                        par_en_q, par_mode_q, stop2_q;
  logic                        par_bit_q, ferr_q;
  logic                        din_s, bit_val, sample;
  logic                        frame_done, brk, stop_ferr, load;

  function automatic logic [WLW-1:0] clamp_wl(input logic [WLW-1:0] wl);
    if (wl < WLW'(UART_MIN_WORD_WIDTH)) return WLW'(UART_MIN_WORD_WIDTH);
    if (wl > WLW'(MAX_WORD_WIDTH))      return WLW'(MAX_WORD_WIDTH);
    return wl;
  endfunction

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (din),
    .q     (din_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    hist_q <= 2'b11;
    else if (tick) hist_q <= {hist_q[0], din_s};
  end

  assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & din_s) | (hist_q[0] & din_s);
`else
  assign bit_val = din_s;
`endif

  assign sample = tick && (tick_ctr_q == '0);
  assign busy   = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    brk        = 1'b0;
    stop_ferr  = ferr_q;
    case (state_q)
      ST_IDLE:   if (!din_s) state_d = ST_START;
      ST_START:  if (sample) state_d = bit_val ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (sample && (bit_ctr_q == wl_q - WLW'(1)))
          state_d = par_en_q ? ST_PARITY : ST_STOP1;
      end
      ST_PARITY: if (sample) state_d = ST_STOP1;
      ST_STOP1: begin
        if (sample) begin
          stop_ferr = ferr_q | ~bit_val;
          if (!bit_val && (shreg_q == '0) && !(par_en_q && par_bit_q)) begin
            brk     = 1'b1;
            state_d = ST_BREAK_WAIT;
          end else if (stop2_q) begin
            state_d = ST_STOP2;
          end else begin
            frame_done = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_STOP2: begin
        if (sample) begin
          stop_ferr  = ferr_q | ~bit_val;
          frame_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_BREAK_WAIT: if (din_s) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Frame capture: counters, latched config and the assembling word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_ctr_q <= '0;
      bit_ctr_q  <= '0;
      wl_q       <= WLW'(UART_MIN_WORD_WIDTH);
      shreg_q    <= '0;
      par_en_q   <= 1'b0;
      par_mode_q <= UART_PARITY_EVEN;
      stop2_q    <= 1'b0;
      par_bit_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (!din_s) begin
        tick_ctr_q <= START_LOAD;
        bit_ctr_q  <= '0;
        wl_q       <= clamp_wl(cfg_word_len);
        shreg_q    <= '0;
        par_en_q   <= cfg_parity_en;
        par_mode_q <= cfg_parity_odd ? UART_PARITY_ODD : UART_PARITY_EVEN;
        stop2_q    <= cfg_stop2;
        par_bit_q  <= 1'b0;
        ferr_q     <= 1'b0;
      end
    end else if (state_q != ST_BREAK_WAIT) begin
      if (sample) begin
        tick_ctr_q <= BIT_LOAD;
        if (state_q == ST_DATA) begin
          for (int i = 0; i < MAX_WORD_WIDTH; i++)
            if (bit_ctr_q == WLW'(i)) shreg_q[i] <= bit_val;
          bit_ctr_q <= bit_ctr_q + WLW'(1);
        end
        if (state_q == ST_PARITY) par_bit_q <= bit_val;
        if (state_q == ST_STOP1 || state_q == ST_STOP2) ferr_q <= stop_ferr;
      end else if (tick) begin
        tick_ctr_q <= tick_ctr_q - CW'(1);
      end
    end
  end

  assign load = frame_done && (!dout_valid || dout_ready);

  // Output holding register and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      break_det <= brk;
      overrun   <= frame_done && dout_valid && !dout_ready;
      if (load) begin
        dout       <= shreg_q;
        parity_err <= par_en_q && ((^shreg_q ^ par_bit_q) != (par_mode_q == UART_PARITY_ODD));
        frame_err  <= stop_ferr;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deser_cfg.sv
// Scoreboard bench for uart_rx_deser_cfg: directed frames plus randomized
// configurations, checked against a frame-level reference model.
module tb_uart_rx_deser_cfg;

  localparam int MAXW = 9;
  localparam int OS   = 16;
  localparam int TDIV = 2;
  localparam int BITC = OS * TDIV;
  localparam int WLW  = $clog2(MAXW + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            tick = 1'b0;
  logic            din = 1'b1;
  logic [WLW-1:0]  cfg_word_len = WLW'(8);
  logic            cfg_parity_en = 1'b0;
  logic            cfg_parity_odd = 1'b0;
  logic            cfg_stop2 = 1'b0;
  logic            dout_ready = 1'b1;
  logic [MAXW-1:0] dout;
  logic            dout_valid, parity_err, frame_err, break_det, overrun, busy;

  typedef struct {
    logic [MAXW-1:0] data;
    logic            perr;
    logic            ferr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0, n_err = 0;
  int   exp_break = 0, exp_ovr = 0, seen_break = 0, seen_ovr = 0;
  bit   ready_rand = 1'b0;
  bit   model_full = 1'b0;

  always #5 clk = ~clk;

  uart_rx_deser_cfg #(.MAX_WORD_WIDTH(MAXW), .OVERSAMPLING(OS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick          (tick),
    .din           (din),
    .cfg_word_len  (cfg_word_len),
    .cfg_parity_en (cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd),
    .cfg_stop2     (cfg_stop2),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .parity_err    (parity_err),
    .frame_err     (frame_err),
    .break_det     (break_det),
    .overrun       (overrun),
    .busy          (busy)
  );

  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clk); #1;
      tick = (c == 0);
      c = (c + 1) % TDIV;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (ready_rand) dout_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d required 0", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (break_det) seen_break++;
      if (overrun)   seen_ovr++;
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got dout 0x%0h, expected no frame", dout);
        end else begin
          mon_e = exp_q.pop_front();
          check("dout", 32'(dout), 32'(mon_e.data));
          check("parity_err", 32'(parity_err), 32'(mon_e.perr));
          check("frame_err", 32'(frame_err), 32'(mon_e.ferr));
        end
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Reference: what a frame on the line should produce, from the protocol rules.
  function automatic void model_frame(input logic [MAXW-1:0] word, input logic [WLW-1:0] cfg_wl,
                                      input bit pen, input bit podd, input bit pbit,
                                      input bit s2en, input bit s1, input bit s2);
    int wl, ones;
    logic [MAXW-1:0] data;
    exp_t e;
    wl = (cfg_wl < 5) ? 5 : ((cfg_wl > MAXW) ? MAXW : int'(cfg_wl));
    data = '0;
    ones = 0;
    for (int i = 0; i < wl; i++) begin
      data[i] = word[i];
      ones += int'(word[i]);
    end
    if (data == '0 && (!pen || !pbit) && !s1) begin
      exp_break++;
      return;
    end
    e.data = data;
    e.perr = pen && (((ones + int'(pbit)) % 2) != int'(podd));
    e.ferr = !s1 || (s2en && !s2);
    if (!ready_rand && !dout_ready && model_full) begin
      exp_ovr++;
    end else begin
      exp_q.push_back(e);
      if (!ready_rand && !dout_ready) model_full = 1'b1;
    end
  endfunction

  task automatic send_bit(input bit b, input bit short_low);
    if (!b && short_low) begin
      din = 1'b0; wait_clks(3 * BITC / 4);
      din = 1'b1; wait_clks(BITC / 4);
    end else begin
      din = b; wait_clks(BITC);
    end
  endtask

  task automatic send_frame(input logic [MAXW-1:0] word, input logic [WLW-1:0] cfg_wl,
                            input bit pen, input bit podd, input bit pbit,
                            input bit s2en, input bit s1, input bit s2, input int glitch_bit);
    int wl;
    wl = (cfg_wl < 5) ? 5 : ((cfg_wl > MAXW) ? MAXW : int'(cfg_wl));
    cfg_word_len = cfg_wl;
    cfg_parity_en = pen;
    cfg_parity_odd = podd;
    cfg_stop2 = s2en;
    model_frame(word, cfg_wl, pen, podd, pbit, s2en, s1, s2);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < wl; i++) begin
      if (i == glitch_bit) begin
        din = word[i];  wait_clks(BITC / 2);
        din = ~word[i]; wait_clks(TDIV);
        din = word[i];  wait_clks(BITC / 2 - TDIV);
      end else begin
        send_bit(word[i], 1'b0);
      end
    end
    if (pen) send_bit(pbit, 1'b0);
    send_bit(s1, 1'b1);
    if (s2en) send_bit(s2, 1'b1);
    din = 1'b1;
    wait_clks(BITC);
  endtask

  initial begin
    logic [MAXW-1:0] w;
    logic [WLW-1:0]  cw;
    bit pen, podd, pbit, s2en, s1, s2;

    rst_n = 1'b0;
    wait_clks(5);
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_dout_valid", 32'(dout_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_break_det", 32'(break_det), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    wait_clks(5);

    send_frame(9'h0A5, WLW'(8), 0, 0, 0, 0, 1, 1, -1);
    check("busy_after_8n1", 32'(busy), 32'h0);
    send_frame(9'h035, WLW'(7), 1, 0, 1, 0, 1, 1, -1);
    send_frame(9'h035, WLW'(7), 1, 1, 1, 0, 1, 1, -1);
    send_frame(9'h03C, WLW'(8), 0, 0, 0, 1, 1, 0, -1);
    check("busy_after_8n2", 32'(busy), 32'h0);

    cfg_word_len = WLW'(8); cfg_parity_en = 0; cfg_stop2 = 0;
    din = 1'b0; wait_clks(4 * TDIV);
    din = 1'b1; wait_clks(2 * BITC);
    check("busy_after_false_start", 32'(busy), 32'h0);

`ifdef UART_RX_MAJORITY_EN
    send_frame(9'h0A5, WLW'(8), 0, 0, 0, 0, 1, 1, 1);
`endif

    exp_break++;
    din = 1'b0; wait_clks(12 * BITC);
    check("busy_during_break", 32'(busy), 32'h1);
    check("break_pulses", 32'(seen_break), 32'(exp_break));
    din = 1'b1; wait_clks(10);
    check("busy_after_break", 32'(busy), 32'h0);

    ready_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      w    = MAXW'($urandom_range(0, (1 << MAXW) - 1));
      if ($urandom_range(0, 7) == 0) w = '0;
      cw   = ($urandom_range(0, 3) == 0) ? WLW'($urandom_range(0, (1 << WLW) - 1))
                                         : WLW'($urandom_range(5, MAXW));
      pen  = $urandom_range(0, 1);
      podd = $urandom_range(0, 1);
      pbit = $urandom_range(0, 1);
      s2en = $urandom_range(0, 1);
      s1   = ($urandom_range(0, 7) != 0);
      s2   = ($urandom_range(0, 7) != 0);
      send_frame(w, cw, pen, podd, pbit, s2en, s1, s2, -1);
    end
    ready_rand = 1'b0;
    wait_clks(2);
    dout_ready = 1'b1;
    wait_clks(20);
    check("queue_drained_random", 32'(exp_q.size()), 32'h0);

    dout_ready = 1'b0;
    model_full = 1'b0;
    send_frame(9'h011, WLW'(8), 0, 0, 0, 0, 1, 1, -1);
    send_frame(9'h022, WLW'(8), 0, 0, 0, 0, 1, 1, -1);
    check("overrun_hold_dout", 32'(dout), 32'h011);
    check("overrun_hold_valid", 32'(dout_valid), 32'h1);
    check("overrun_pulses", 32'(seen_ovr), 32'(exp_ovr));

    din = 1'b0; wait_clks(3 * BITC);
    rst_n = 1'b0;
    #1;
    check("midreset_dout", 32'(dout), 32'h0);
    check("midreset_valid", 32'(dout_valid), 32'h0);
    check("midreset_busy", 32'(busy), 32'h0);
    check("midreset_flags", 32'({parity_err, frame_err, break_det, overrun}), 32'h0);
    exp_q.delete();
    model_full = 1'b0;
    din = 1'b1;
    wait_clks(4);
    rst_n = 1'b1;
    dout_ready = 1'b1;
    wait_clks(2 * BITC);
    send_frame(9'h155, WLW'(9), 1, 0, 1, 0, 1, 1, -1);

    wait_clks(20);
    check("queue_drained_final", 32'(exp_q.size()), 32'h0);
    check("break_total", 32'(seen_break), 32'(exp_break));
    check("overrun_total", 32'(seen_ovr), 32'(exp_ovr));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
